// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - oversampling UART receiver with 3-sample majority vote
module uart_rx_oversampled #(
    parameter int DATA_WD     = 8,
    parameter int PRESCALE_WD = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RX_IN,
    input  logic [PRESCALE_WD-1:0] Prescale,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    output logic [DATA_WD-1:0]     P_DATA,
    output logic                   data_valid,
    output logic                   parity_error,
    output logic                   stop_error
);

    localparam int BIT_CW = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [PRESCALE_WD-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WD-1:0] presc_q, presc_d;
    logic [BIT_CW-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WD-1:0]     shift_q, shift_d;
    logic [DATA_WD-1:0]     p_data_q, p_data_d;
    logic [2:0]             smp_q, smp_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   par_err_q, par_err_d;
    logic                   data_valid_q, data_valid_d;
    logic                   parity_error_q, parity_error_d;
    logic                   stop_error_q, stop_error_d;

    logic [PRESCALE_WD-1:0] cfg_presc;
    logic [PRESCALE_WD-1:0] half;
    logic [PRESCALE_WD-1:0] bit_last;
    logic                   bit_end;
    logic                   vote;
    logic                   par_exp;

    // Anything other than 16 or 32 clocks per bit falls back to 8
    always_comb begin
        if (Prescale == PRESCALE_WD'(16) || Prescale == PRESCALE_WD'(32)) begin
            cfg_presc = Prescale;
        end else begin
            cfg_presc = PRESCALE_WD'(8);
        end
    end

    assign half     = presc_q >> 1;
    assign bit_last = presc_q - PRESCALE_WD'(1);
    assign bit_end  = (edge_cnt_q == bit_last);
    assign vote     = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    assign par_exp  = par_typ_q ? ~^shift_q : ^shift_q;

    // Next-state, counters, mid-bit sampling and registered frame result
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        presc_d        = presc_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        p_data_d       = p_data_q;
        smp_d          = smp_q;
        par_en_d       = par_en_q;
        par_typ_d      = par_typ_q;
        par_err_d      = par_err_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_WD'(1);
            if (edge_cnt_q == half - PRESCALE_WD'(1)) begin
                smp_d[0] = RX_IN;
            end else if (edge_cnt_q == half) begin
                smp_d[1] = RX_IN;
            end else if (edge_cnt_q == half + PRESCALE_WD'(1)) begin
                smp_d[2] = RX_IN;
            end
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    state_d   = S_START;
                    presc_d   = cfg_presc;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    // A start bit that votes high was a line glitch
                    state_d   = vote ? S_IDLE : S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d[bit_cnt_q] = vote;
                    if (bit_cnt_q == BIT_CW'(DATA_WD - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    par_err_d = (vote != par_exp);
                    state_d   = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    parity_error_d = par_err_q;
                    stop_error_d   = ~vote;
                    if (vote && !par_err_q) begin
                        data_valid_d = 1'b1;
                        p_data_d     = shift_q;
                    end
                    // Line already low here means the next start bit has begun
                    if (!RX_IN) begin
                        state_d   = S_START;
                        bit_cnt_d = '0;
                        presc_d   = cfg_presc;
                        par_en_d  = PAR_EN;
                        par_typ_d = PAR_TYP;
                        par_err_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            edge_cnt_q     <= '0;
            presc_q        <= PRESCALE_WD'(8);
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            p_data_q       <= '0;
            smp_q          <= '0;
            par_en_q       <= 1'b0;
            par_typ_q      <= 1'b0;
            par_err_q      <= 1'b0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            presc_q        <= presc_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            p_data_q       <= p_data_d;
            smp_q          <= smp_d;
            par_en_q       <= par_en_d;
            par_typ_q      <= par_typ_d;
            par_err_q      <= par_err_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- UART receiver, the receive-side counterpart to the team's UART transmitter.
- Deserialises a frame from RX_IN in this order: start bit (0), DATA_WD data bits LSB first, optional parity bit, stop bit (1).
- Runs on an oversampling clock at Prescale × baud. Recovers each bit by 3-sample majority vote.
- Presents the parallel byte to the register file / SYS_CTRL with a one-cycle valid pulse plus error flags.

Parameters:
DATA_WD, 8, data bits per frame
PRESCALE_WD, 6, width of Prescale input

Ports:
clk  input  1  oversampling clock (Prescale × baud)
reset  input  1  asynchronous, active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  PRESCALE_WD  clocks per bit; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WD  last correctly received byte
data_valid  output  1  one-cycle pulse, new byte on P_DATA
parity_error  output  1  one-cycle pulse, parity mismatch
stop_error  output  1  one-cycle pulse, stop bit sampled 0

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to IDLE; all counters are cleared.
  - Outputs: P_DATA=0, data_valid=0, parity_error=0, stop_error=0.
  - Reset mid-frame abandons the frame with no output pulse.
- Config latch: Prescale, PAR_EN and PAR_TYP are captured on the IDLE→START transition and held for the whole frame. Mid-frame changes are ignored. An unsupported Prescale is treated as 8.
- Counters:
  - edge_cnt runs 0..Prescale-1 within each bit and wraps to 0 at bit end.
  - bit_cnt counts data bits 0..DATA_WD-1.
- Sampling: RX_IN is registered at edge_cnt = P/2-1, P/2 and P/2+1 (P = latched Prescale). The bit value is the majority of the 3 samples, valid from edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when RX_IN=0, go to START with edge_cnt=0; otherwise stay.
  - START:
    - At edge_cnt=P-1, go to DATA if the voted bit is 0.
    - If the voted bit is 1 (glitch), go to IDLE with no flags.
  - DATA:
    - At each edge_cnt=P-1, shift the voted bit into the shift register at position bit_cnt (LSB first).
    - After bit DATA_WD-1, go to PARITY if PAR_EN=1, else to STOP.
  - PARITY:
    - Expected bit = ^data when even, ~^data when odd.
    - At edge_cnt=P-1, record whether the voted bit mismatches the expected bit, then go to STOP.
  - STOP:
    - At edge_cnt=P-1, evaluate the frame.
    - If RX_IN=0 in that same cycle, go directly to START with edge_cnt=0 (back-to-back frames). Otherwise go to IDLE.
- Frame result, registered and visible in the cycle after the last stop-bit clock:
  - Stop voted 1 and no parity mismatch: load P_DATA and pulse data_valid=1 for one cycle.
  - Parity mismatch: pulse parity_error; data_valid stays 0 and P_DATA is unchanged.
  - Stop voted 0: pulse stop_error; data_valid stays 0 and P_DATA is unchanged.
  - Both errors together: both flags pulse in the same cycle.
- P_DATA holds its value between frames.
- Latency: data_valid rises (1 + DATA_WD + PAR_EN + 1) × P + 1 clocks after the IDLE cycle that saw RX_IN=0. That is 10P+1 without parity and 11P+1 with parity.
- The block never stalls. A back-to-back frame at full rate is received without losing bits.

Test Plan:
- Prescale=8, PAR_EN=0, frame 0xA3 (line: 0, 1,1,0,0,0,1,0,1, 1) → P_DATA=0xA3; data_valid high exactly one cycle, 81 clocks after start detection; both error flags stay 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, frame 0xB4 with parity bit 0 → P_DATA=0xB4, data_valid pulse, parity_error=0. Repeat with parity bit 1 → parity_error pulse, data_valid=0, P_DATA still 0xB4.
- Prescale=32, PAR_EN=1, PAR_TYP=1, frame 0xD2 with parity bit 1 → P_DATA=0xD2, single data_valid pulse. Then send 0x5A with stop bit 0 → stop_error pulse, P_DATA stays 0xD2.
- Prescale=8, RX_IN low for 2 clocks then high → no state leaves IDLE after the START check, no output pulses. Also inject a 1-clock glitch at a data-bit sample point → majority vote masks it and the correct byte is received.
- Back-to-back frames 0x11 then 0xEE with zero idle time at Prescale=16 → two data_valid pulses, exactly 160 clocks apart, with the correct bytes.
- Assert reset mid-DATA of frame 0x77, release, then send 0x3C → no pulse for 0x77; P_DATA=0x3C with one data_valid pulse; all outputs 0 while reset is asserted.
